pong_game_ctrl: RTL and testbench

Game-sequencing controller for the board-level ping-pong design. It owns the rally state machine and moves a one-hot "ball" across the 16 LEDs. It also detects paddle hits from the two end switches and keeps both scores. Score values go to the existing 7-segment scan logic; led drives LED[15:0] directly.

---
 rtl/pong_pkg.sv | 19 +
 rtl/tick_gen.sv | 37 +++
 rtl/pong_game_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants and state encoding for the ping-pong game controller.
package pong_pkg;

    localparam int LED_W = 16;

    localparam logic [LED_W-1:0] LED_LEFT_END  = 16'h8000;
    localparam logic [LED_W-1:0] LED_RIGHT_END = 16'h0001;
    localparam logic [LED_W-1:0] LED_LEFT_WIN  = 16'hFF00;
    localparam logic [LED_W-1:0] LED_RIGHT_WIN = 16'h00FF;

    typedef enum logic [2:0] {
        SERVE     = 3'd0,
        MOVE_R    = 3'd1,
        MOVE_L    = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4
    } state_e;

endpackage

// File: rtl/tick_gen.sv
// Ball-step timebase: counts 0..TICK_DIV-1 and pulses tick_o on the last count.
module tick_gen #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/pong_game_ctrl.sv
// Rally sequencer for the ping-pong board: switch synchronisers, press detection,
// ball movement across the LEDs, point hold/flash and score keeping.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int TICK_DIV   = 12_500_000,
    parameter int POINT_HOLD = 4,
    parameter int WIN_SCORE  = 9
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             sw_left,
    input  logic             sw_right,
    output logic [LED_W-1:0] led,
    output logic [3:0]       score_l,
    output logic [3:0]       score_r,
    output logic             server,
    output logic             game_over
);

    localparam int HW = $clog2(POINT_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(POINT_HOLD - 1);
    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    logic [1:0] syncLeft_q, syncRight_q;
    logic       prevLeft_q, prevRight_q;
    logic       pressLeft_q, pressRight_q;

    state_e           state_q, state_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [3:0]       scoreL_q, scoreL_d;
    logic [3:0]       scoreR_q, scoreR_d;
    logic             server_q, server_d;
    logic             gameOver_q, gameOver_d;
    logic             winnerRight_q, winnerRight_d;
    logic [HW-1:0]    holdCnt_q, holdCnt_d;

    logic       tick;
    logic [3:0] newScore;

    // Any level change on a switch is a press; the pulse is registered so it lands 3 clk after the pin.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            syncLeft_q   <= '0;
            syncRight_q  <= '0;
            prevLeft_q   <= 1'b0;
            prevRight_q  <= 1'b0;
            pressLeft_q  <= 1'b0;
            pressRight_q <= 1'b0;
        end else begin
            syncLeft_q   <= {syncLeft_q[0], sw_left};
            syncRight_q  <= {syncRight_q[0], sw_right};
            prevLeft_q   <= syncLeft_q[1];
            prevRight_q  <= syncRight_q[1];
            pressLeft_q  <= syncLeft_q[1] ^ prevLeft_q;
            pressRight_q <= syncRight_q[1] ^ prevRight_q;
        end
    end

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .resetn  (resetn),
        .clear_i (state_d != state_q),
        .tick_o  (tick)
    );

    assign newScore = (winnerRight_q ? scoreR_q : scoreL_q) + 4'd1;

    // A hit press at the end position takes priority over a same-cycle tick.
    always_comb begin
        state_d       = state_q;
        led_d         = led_q;
        scoreL_d      = scoreL_q;
        scoreR_d      = scoreR_q;
        server_d      = server_q;
        gameOver_d    = gameOver_q;
        winnerRight_d = winnerRight_q;
        holdCnt_d     = holdCnt_q;
        case (state_q)
            SERVE: begin
                led_d = server_q ? LED_RIGHT_END : LED_LEFT_END;
                if (!server_q && pressLeft_q) begin
                    state_d = MOVE_R;
                end else if (server_q && pressRight_q) begin
                    state_d = MOVE_L;
                end
            end
            MOVE_R: begin
                if (led_q == LED_RIGHT_END) begin
                    if (pressRight_q) begin
                        state_d = MOVE_L;
                    end else if (tick) begin
                        state_d       = POINT;
                        winnerRight_d = 1'b0;
                        holdCnt_d     = '0;
                        led_d         = '0;
                    end
                end else if (tick) begin
                    led_d = led_q >> 1;
                end
            end
            MOVE_L: begin
                if (led_q == LED_LEFT_END) begin
                    if (pressLeft_q) begin
                        state_d = MOVE_R;
                    end else if (tick) begin
                        state_d       = POINT;
                        winnerRight_d = 1'b1;
                        holdCnt_d     = '0;
                        led_d         = '0;
                    end
                end else if (tick) begin
                    led_d = led_q << 1;
                end
            end
            POINT: begin
                if (tick) begin
                    if (holdCnt_q == HOLD_LAST) begin
                        if (winnerRight_q) begin
                            scoreR_d = newScore;
                        end else begin
                            scoreL_d = newScore;
                        end
                        if (newScore == WIN) begin
                            state_d    = GAME_OVER;
                            gameOver_d = 1'b1;
                            led_d      = winnerRight_q ? LED_RIGHT_WIN : LED_LEFT_WIN;
                        end else begin
                            state_d  = SERVE;
                            server_d = ~winnerRight_q;
                            led_d    = winnerRight_q ? LED_LEFT_END : LED_RIGHT_END;
                        end
                    end else begin
                        holdCnt_d = holdCnt_q + 1'b1;
                        led_d     = holdCnt_q[0] ? '0 : '1;
                    end
                end
            end
            GAME_OVER: begin
                gameOver_d = 1'b1;
            end
            default: begin
                state_d = SERVE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= SERVE;
            led_q         <= LED_LEFT_END;
            scoreL_q      <= '0;
            scoreR_q      <= '0;
            server_q      <= 1'b0;
            gameOver_q    <= 1'b0;
            winnerRight_q <= 1'b0;
            holdCnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            led_q         <= led_d;
            scoreL_q      <= scoreL_d;
            scoreR_q      <= scoreR_d;
            server_q      <= server_d;
            gameOver_q    <= gameOver_d;
            winnerRight_q <= winnerRight_d;
            holdCnt_q     <= holdCnt_d;
        end
    end

    assign led       = led_q;
    assign score_l   = scoreL_q;
    assign score_r   = scoreR_q;
    assign server    = server_q;
    assign game_over = gameOver_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: every expected output change is queued with
// its cycle distance from the last event, and a negedge monitor pops and compares.
module tb_pong_game_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        sw_left = 1'b0;
    logic        sw_right = 1'b0;
    logic [15:0] led;
    logic [3:0]  score_l, score_r;
    logic        server, game_over;

    typedef struct {
        logic [25:0] snap;
        int          gap;
    } exp_t;

    exp_t        expQ[$];
    int          testsRun = 0;
    int          testsFailed = 0;
    int          cycleCnt = 0;
    int          refCycle = 0;
    int          snapIdx = 0;
    logic [15:0] expLed = 16'h8000;
    logic [3:0]  expSl = 4'd0, expSr = 4'd0;
    logic        expSrv = 1'b0, expGo = 1'b0;
    logic [25:0] prevSnap = {16'h8000, 4'd0, 4'd0, 1'b0, 1'b0};

    pong_game_ctrl #(
        .TICK_DIV   (4),
        .POINT_HOLD (2),
        .WIN_SCORE  (3)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .sw_left   (sw_left),
        .sw_right  (sw_right),
        .led       (led),
        .score_l   (score_l),
        .score_r   (score_r),
        .server    (server),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic pushCur(input int gap);
        exp_t e;
        e.snap = {expLed, expSl, expSr, expSrv, expGo};
        e.gap  = gap;
        expQ.push_back(e);
    endtask

    task automatic pushSweep(input logic [15:0] start, input bit right, input int n, input int firstGap);
        expLed = start;
        for (int i = 0; i < n; i++) begin
            expLed = right ? (expLed >> 1) : (expLed << 1);
            pushCur((i == 0) ? firstGap : 4);
        end
    endtask

    task automatic pushPoint(input bit leftWins);
        expLed = 16'h0000;
        pushCur(4);
        expLed = 16'hFFFF;
        pushCur(4);
        if (leftWins) expSl = expSl + 4'd1;
        else          expSr = expSr + 4'd1;
        if ((leftWins ? expSl : expSr) == 4'd3) begin
            expGo  = 1'b1;
            expLed = leftWins ? 16'hFF00 : 16'h00FF;
        end else begin
            expSrv = leftWins;
            expLed = leftWins ? 16'h0001 : 16'h8000;
        end
        pushCur(4);
    endtask

    task automatic applyStimulus(input bit toggleLeft, input bit toggleRight);
        if (toggleLeft)  sw_left  = ~sw_left;
        if (toggleRight) sw_right = ~sw_right;
        refCycle = cycleCnt;
    endtask

    task automatic waitDrain(input int maxCycles);
        int n = 0;
        while (expQ.size() != 0 && n < maxCycles) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (expQ.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL drain_timeout: %0d expected changes never seen, expected 0 pending", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_led"}, 32'(led), 32'h8000);
        checkOutput({tag, "_score_l"}, 32'(score_l), 32'd0);
        checkOutput({tag, "_score_r"}, 32'(score_r), 32'd0);
        checkOutput({tag, "_server"}, 32'(server), 32'd0);
        checkOutput({tag, "_game_over"}, 32'(game_over), 32'd0);
    endtask

    // Async reset is checked before any clock edge can occur.
    task automatic doReset(input string tag);
        expLed = 16'h8000;
        expSl  = 4'd0;
        expSr  = 4'd0;
        expSrv = 1'b0;
        expGo  = 1'b0;
        pushCur(0);
        #1;
        resetn   = 1'b0;
        sw_left  = 1'b0;
        sw_right = 1'b0;
        #1;
        checkResetValues(tag);
        repeat (3) @(negedge clk);
        #1;
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [25:0] snap;
        exp_t        e;
        snap = {led, score_l, score_r, server, game_over};
        if (snap !== prevSnap) begin
            if (expQ.size() == 0) begin
                checkOutput($sformatf("unexpected_change%0d", snapIdx), 32'(snap), 32'(prevSnap));
            end else begin
                e = expQ.pop_front();
                checkOutput($sformatf("snap%0d", snapIdx), 32'(snap), 32'(e.snap));
                if (e.gap != 0) begin
                    checkOutput($sformatf("gap%0d", snapIdx), 32'(cycleCnt - refCycle), 32'(e.gap));
                end
            end
            snapIdx++;
            prevSnap = snap;
            refCycle = cycleCnt;
        end
    end

    initial begin
        #1;
        resetn = 1'b0;
        #1;
        checkResetValues("init_reset");
        repeat (3) @(negedge clk);
        #1;
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        #1;

        // Left serves, ball runs to the right end.
        pushSweep(16'h8000, 1'b1, 15, 8);
        applyStimulus(1'b1, 1'b0);
        waitDrain(200);

        // Right hits at the end on the same cycle as a tick, ball returns.
        pushSweep(16'h0001, 1'b0, 15, 8);
        applyStimulus(1'b0, 1'b1);
        waitDrain(200);

        pushSweep(16'h8000, 1'b1, 7, 8);
        applyStimulus(1'b1, 1'b0);
        waitDrain(200);

        // Both switches mid-flight are ignored, then right misses.
        pushSweep(16'h0100, 1'b1, 8, 4);
        applyStimulus(1'b1, 1'b1);
        waitDrain(200);
        pushPoint(1'b1);
        waitDrain(200);

        // Right serves (left press in SERVE ignored), left misses.
        applyStimulus(1'b1, 1'b0);
        repeat (10) @(negedge clk);
        #1;
        pushSweep(16'h0001, 1'b0, 15, 8);
        applyStimulus(1'b0, 1'b1);
        waitDrain(200);
        pushPoint(1'b0);
        waitDrain(200);

        pushSweep(16'h8000, 1'b1, 15, 8);
        applyStimulus(1'b1, 1'b0);
        waitDrain(200);
        pushPoint(1'b1);
        waitDrain(200);

        pushSweep(16'h0001, 1'b0, 15, 8);
        applyStimulus(1'b0, 1'b1);
        waitDrain(200);
        pushSweep(16'h8000, 1'b1, 15, 8);
        applyStimulus(1'b1, 1'b0);
        waitDrain(200);
        pushPoint(1'b1);
        waitDrain(200);

        // Game over: presses must not change anything.
        applyStimulus(1'b1, 1'b0);
        repeat (20) @(negedge clk);
        applyStimulus(1'b0, 1'b1);
        repeat (20) @(negedge clk);
        applyStimulus(1'b1, 1'b1);
        repeat (20) @(negedge clk);
        #1;
        checkOutput("final_game_over", 32'(game_over), 32'd1);
        checkOutput("final_led", 32'(led), 32'hFF00);
        checkOutput("final_score_l", 32'(score_l), 32'd3);

        doReset("reset_from_game_over");

        pushSweep(16'h8000, 1'b1, 9, 8);
        applyStimulus(1'b1, 1'b0);
        waitDrain(200);
        doReset("reset_mid_rally");

        pushSweep(16'h8000, 1'b1, 3, 8);
        applyStimulus(1'b1, 1'b0);
        waitDrain(200);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #100000;
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
